// File: rtl/pc_pkg.sv
// Shared types and default address map for the fetch-address generator.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_RUN,
        PC_HALT
    } pc_state_e;

    localparam int unsigned PC_AW        = 32;
    localparam int unsigned PC_CW        = 32;
    localparam int unsigned PC_STEP      = 4;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] PC_ADDR_LO   = 32'h0000_3000;
    localparam logic [31:0] PC_ADDR_HI   = 32'h0000_6FFC;
    localparam logic [31:0] PC_FAULT_VEC = 32'h0000_4180;

endpackage

// File: rtl/pc_if.sv
// Fetch-address bus between the NPC/branch logic (master) and pc_unit (slave).
interface pc_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 32
);
    logic          stall_i;
    logic          redirect_valid_i;
    logic [AW-1:0] redirect_target_i;
    logic [AW-1:0] pc_o;
    logic [AW-1:0] pc_plus_o;
    logic          pc_valid_o;
    logic          halted_o;
    logic          fault_o;
    logic [AW-1:0] fault_addr_o;
    logic [CW-1:0] fetch_cnt_o;

    modport master (
        output stall_i, redirect_valid_i, redirect_target_i,
        input  pc_o, pc_plus_o, pc_valid_o, halted_o, fault_o, fault_addr_o, fetch_cnt_o
    );

    modport slave (
        input  stall_i, redirect_valid_i, redirect_target_i,
        output pc_o, pc_plus_o, pc_valid_o, halted_o, fault_o, fault_addr_o, fetch_cnt_o
    );
endinterface

// File: rtl/pc_window_chk.sv
// Combinational legality check of a candidate fetch address against the instruction window.
module pc_window_chk #(
    parameter int unsigned   AW = 32,
    parameter logic [AW-1:0] LO = '0,
    parameter logic [AW-1:0] HI = '1
) (
    input  logic [AW-1:0] addr_i,
    output logic          in_window_o,
    output logic          aligned_o
);
    // Unsigned full-width compare: a wrapped address lands below LO and fails.
    assign in_window_o = (addr_i >= LO) && (addr_i <= HI);
    assign aligned_o   = (addr_i[1:0] == 2'b00);
endmodule

// File: rtl/pc_unit.sv
// IF-stage PC generator: BOOT/RUN/HALT FSM, stall hold, redirects, saturating fetch counter.
// Optional fault path enabled by macro PC_FAULT_EN (illegal redirect -> FAULT_VEC instead of halt).
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned   AW        = PC_AW,
    parameter logic [AW-1:0] RESET_VEC = AW'(PC_RESET_VEC),
    parameter logic [AW-1:0] ADDR_LO   = AW'(PC_ADDR_LO),
    parameter logic [AW-1:0] ADDR_HI   = AW'(PC_ADDR_HI),
    parameter int unsigned   STEP      = PC_STEP,
    parameter logic [AW-1:0] FAULT_VEC = AW'(PC_FAULT_VEC),
    parameter int unsigned   CW        = PC_CW
) (
    input  logic clk,
    input  logic rst_n,
    pc_if.slave  bus
);

    pc_state_e     state_q;
    logic [AW-1:0] pc_q;
    logic [CW-1:0] cnt_q;
    logic          pc_valid_q;
    logic          halted_q;

    logic [AW-1:0] seq_pc;
    logic [AW-1:0] cand_pc;
    logic [CW-1:0] cnt_d;
    logic          in_window;
    logic          aligned;
    logic          next_legal;

    assign seq_pc     = pc_q + AW'(STEP);
    assign cand_pc    = bus.redirect_valid_i ? bus.redirect_target_i : seq_pc;
    assign next_legal = in_window && aligned;
    assign cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    pc_window_chk #(
        .AW (AW),
        .LO (ADDR_LO),
        .HI (ADDR_HI)
    ) u_chk (
        .addr_i      (cand_pc),
        .in_window_o (in_window),
        .aligned_o   (aligned)
    );

`ifdef PC_FAULT_EN
    logic          fault_q;
    logic [AW-1:0] fault_addr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PC_BOOT;
            pc_q       <= RESET_VEC;
            cnt_q      <= '0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
`ifdef PC_FAULT_EN
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
`endif
        end else begin
`ifdef PC_FAULT_EN
            fault_q <= 1'b0;
`endif
            case (state_q)
                // One dead cycle so the IM read of RESET_VEC lines up with pc_valid_o.
                PC_BOOT: begin
                    state_q    <= PC_RUN;
                    pc_valid_q <= 1'b1;
                end
                PC_RUN: begin
                    if (!bus.stall_i) begin
                        if (next_legal) begin
                            pc_q  <= cand_pc;
                            cnt_q <= cnt_d;
                        end
`ifdef PC_FAULT_EN
                        else if (bus.redirect_valid_i) begin
                            pc_q         <= FAULT_VEC;
                            fault_q      <= 1'b1;
                            fault_addr_q <= bus.redirect_target_i;
                            cnt_q        <= cnt_d;
                        end
`endif
                        else begin
                            pc_q       <= cand_pc;
                            state_q    <= PC_HALT;
                            pc_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_o        = pc_q;
    assign bus.pc_plus_o   = seq_pc;
    assign bus.pc_valid_o  = pc_valid_q;
    assign bus.halted_o    = halted_q;
    assign bus.fetch_cnt_o = cnt_q;

`ifdef PC_FAULT_EN
    assign bus.fault_o      = fault_q;
    assign bus.fault_addr_o = fault_addr_q;
`else
    logic [AW-1:0] unused_fault_vec;
    assign unused_fault_vec = FAULT_VEC;
    assign bus.fault_o      = 1'b0;
    assign bus.fault_addr_o = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized run against a reference model.
module tb_pc_unit;

    localparam logic [31:0] LO   = 32'h3000;
    localparam logic [31:0] HI   = 32'h6FFC;
    localparam logic [31:0] RVEC = 32'h3000;
    localparam logic [31:0] FVEC = 32'h4180;
    localparam int          CMAX = 15;  // 4-bit counter so saturation is reachable

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    pc_if #(.AW(32), .CW(4)) bus ();

    pc_unit #(.CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = booting, 1 = fetching, 2 = halted.
    int          m_phase;
    logic [31:0] m_pc;
    int          m_cnt;
    logic        m_fault;
    logic [31:0] m_faddr;

    task automatic model_reset();
        m_phase = 0; m_pc = RVEC; m_cnt = 0; m_fault = 1'b0; m_faddr = '0;
    endtask

    task automatic model_edge();
        logic [31:0] nxt;
        bit          ok;
        m_fault = 1'b0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1 && !bus.stall_i) begin
            nxt = bus.redirect_valid_i ? bus.redirect_target_i : m_pc + 32'd4;
            ok  = (nxt >= LO) && (nxt <= HI) && (nxt % 4 == 0);
            if (ok) begin
                m_pc = nxt;
                if (m_cnt < CMAX) m_cnt++;
            end else begin
`ifdef PC_FAULT_EN
                if (bus.redirect_valid_i) begin
                    m_pc = FVEC; m_fault = 1'b1; m_faddr = bus.redirect_target_i;
                    if (m_cnt < CMAX) m_cnt++;
                end else begin
                    m_pc = nxt; m_phase = 2;
                end
`else
                m_pc = nxt; m_phase = 2;
`endif
            end
        end
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] tgt);
        bus.stall_i = st; bus.redirect_valid_i = rv; bus.redirect_target_i = tgt;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.pc_o, bus.pc_valid_o, bus.halted_o, bus.fault_o, bus.fault_addr_o, bus.fetch_cnt_o}
            !== {RVEC, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h v=%b h=%b f=%b fa=%h cnt=%0d, want pc=%h rest 0",
                     bus.pc_o, bus.pc_valid_o, bus.halted_o, bus.fault_o, bus.fault_addr_o, bus.fetch_cnt_o, RVEC);
        end
    endtask

    task automatic test_boot_seq();
        logic [31:0] exp_pc [3] = '{32'h3000, 32'h3004, 32'h3008};
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus.pc_o, bus.pc_valid_o, bus.fetch_cnt_o} !== {exp_pc[i], 1'b1, 4'(i)}) begin
                n_fail++;
                $display("FAIL boot_seq[%0d]: pc=%h v=%b cnt=%0d, want pc=%h v=1 cnt=%0d",
                         i, bus.pc_o, bus.pc_valid_o, bus.fetch_cnt_o, exp_pc[i], i);
            end
        end
        n_checks++;
        if (bus.pc_plus_o !== 32'h300C) begin
            n_fail++;
            $display("FAIL pc_plus: got %h want 0000300c", bus.pc_plus_o);
        end
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b1, 32'h3400);
        tick();
        n_checks++;
        if ({bus.pc_o, bus.fetch_cnt_o} !== {32'h3400, 4'd3}) begin
            n_fail++;
            $display("FAIL redirect_take: pc=%h cnt=%0d, want 3400 cnt=3", bus.pc_o, bus.fetch_cnt_o);
        end
        drive(1'b0, 1'b0, '0);
        tick();
        n_checks++;
        if ({bus.pc_o, bus.fetch_cnt_o} !== {32'h3404, 4'd4}) begin
            n_fail++;
            $display("FAIL redirect_seq: pc=%h cnt=%0d, want 3404 cnt=4", bus.pc_o, bus.fetch_cnt_o);
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 32'h3010);
        tick();
        drive(1'b1, 1'b1, 32'h3200);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus.pc_o, bus.fetch_cnt_o, bus.pc_valid_o} !== {32'h3010, 4'd5, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h cnt=%0d v=%b, want 3010 cnt=5 v=1",
                         i, bus.pc_o, bus.fetch_cnt_o, bus.pc_valid_o);
            end
        end
        drive(1'b0, 1'b0, '0);
        tick();
        n_checks++;
        if ({bus.pc_o, bus.fetch_cnt_o} !== {32'h3014, 4'd6}) begin
            n_fail++;
            $display("FAIL stall_release: pc=%h cnt=%0d, want 3014 cnt=6", bus.pc_o, bus.fetch_cnt_o);
        end
    endtask

    task automatic test_overrun();
        drive(1'b0, 1'b1, HI);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        n_checks++;
        if ({bus.pc_o, bus.halted_o, bus.pc_valid_o, bus.fetch_cnt_o} !== {32'h7000, 1'b1, 1'b0, 4'd7}) begin
            n_fail++;
            $display("FAIL overrun_halt: pc=%h h=%b v=%b cnt=%0d, want 7000 h=1 v=0 cnt=7",
                     bus.pc_o, bus.halted_o, bus.pc_valid_o, bus.fetch_cnt_o);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 1'($urandom), 32'h3000 + 32'($urandom_range(0, 255)) * 4);
            tick();
            n_checks++;
            if ({bus.pc_o, bus.halted_o, bus.pc_valid_o, bus.fetch_cnt_o, bus.fault_o}
                !== {32'h7000, 1'b1, 1'b0, 4'd7, 1'b0}) begin
                n_fail++;
                $display("FAIL halt_frozen[%0d]: pc=%h h=%b v=%b cnt=%0d f=%b, want 7000 h=1 v=0 cnt=7 f=0",
                         i, bus.pc_o, bus.halted_o, bus.pc_valid_o, bus.fetch_cnt_o, bus.fault_o);
            end
        end
    endtask

    task automatic test_fault();
        do_reset();
        tick();
        drive(1'b0, 1'b1, 32'h3002);
        tick();
`ifdef PC_FAULT_EN
        n_checks++;
        if ({bus.pc_o, bus.fault_o, bus.fault_addr_o, bus.pc_valid_o, bus.halted_o, bus.fetch_cnt_o}
            !== {FVEC, 1'b1, 32'h3002, 1'b1, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL fault_take: pc=%h f=%b fa=%h v=%b h=%b cnt=%0d, want 4180 f=1 fa=3002 v=1 h=0 cnt=1",
                     bus.pc_o, bus.fault_o, bus.fault_addr_o, bus.pc_valid_o, bus.halted_o, bus.fetch_cnt_o);
        end
        drive(1'b0, 1'b0, '0);
        tick();
        n_checks++;
        if ({bus.pc_o, bus.fault_o, bus.fault_addr_o, bus.fetch_cnt_o} !== {32'h4184, 1'b0, 32'h3002, 4'd2}) begin
            n_fail++;
            $display("FAIL fault_pulse_end: pc=%h f=%b fa=%h cnt=%0d, want 4184 f=0 fa=3002 cnt=2",
                     bus.pc_o, bus.fault_o, bus.fault_addr_o, bus.fetch_cnt_o);
        end
`else
        n_checks++;
        if ({bus.pc_o, bus.halted_o, bus.pc_valid_o, bus.fault_o, bus.fault_addr_o, bus.fetch_cnt_o}
            !== {32'h3002, 1'b1, 1'b0, 1'b0, 32'h0, 4'd0}) begin
            n_fail++;
            $display("FAIL misalign_halt: pc=%h h=%b v=%b f=%b fa=%h cnt=%0d, want 3002 h=1 v=0 f=0 fa=0 cnt=0",
                     bus.pc_o, bus.halted_o, bus.pc_valid_o, bus.fault_o, bus.fault_addr_o, bus.fetch_cnt_o);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.pc_o, bus.pc_valid_o, bus.halted_o, bus.fetch_cnt_o} !== {RVEC, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL async_reset: pc=%h v=%b h=%b cnt=%0d, want 3000 v=0 h=0 cnt=0",
                     bus.pc_o, bus.pc_valid_o, bus.halted_o, bus.fetch_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.pc_o, bus.pc_valid_o, bus.fetch_cnt_o} !== {32'h3004, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL restart: pc=%h v=%b cnt=%0d, want 3004 v=1 cnt=1",
                     bus.pc_o, bus.pc_valid_o, bus.fetch_cnt_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        logic [31:0] edges [5] = '{32'h2FFC, 32'h6FFC, 32'h7000, 32'hFFFF_FFFC, 32'h0};
        int          halt_wait = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: tgt = LO + 32'($urandom_range(0, (HI - LO) / 4)) * 4;
                3:       tgt = LO + 32'($urandom_range(0, (HI - LO) / 4)) * 4 + 32'($urandom_range(1, 3));
                4:       tgt = $urandom;
                default: tgt = edges[$urandom_range(0, 4)];
            endcase
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, tgt);
            tick();
            n_checks++;
            if ({bus.pc_o, bus.pc_valid_o, bus.halted_o, bus.fault_o, bus.fault_addr_o, bus.fetch_cnt_o}
                !== {m_pc, m_phase == 1, m_phase == 2, m_fault, m_faddr, 4'(m_cnt)}) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%h v=%b h=%b f=%b fa=%h cnt=%0d, want pc=%h v=%b h=%b f=%b fa=%h cnt=%0d",
                         i, bus.pc_o, bus.pc_valid_o, bus.halted_o, bus.fault_o, bus.fault_addr_o, bus.fetch_cnt_o,
                         m_pc, m_phase == 1, m_phase == 2, m_fault, m_faddr, m_cnt);
            end
            n_checks++;
            if (bus.pc_plus_o !== m_pc + 32'd4) begin
                n_fail++;
                $display("FAIL random_pc_plus[%0d]: got %h want %h", i, bus.pc_plus_o, m_pc + 32'd4);
            end
            if (m_phase == 2 && ++halt_wait > 2) begin
                halt_wait = 0;
                do_reset();
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, '0);
        test_reset();
        test_boot_seq();
        test_redirect();
        test_stall();
        test_overrun();
        test_fault();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

endmodule
